// File: rtl/cpu_pkg.sv
// Shared CPU constants, the branch-sequencer state encoding and IR field positions.
//   CPU_DATA_WIDTH   : width of PC, bus and IR
//   CPU_OFFSET_WIDTH : width of the sign-extended branch constant field
//   CPU_RESET_PC     : PC value loaded on reset
package cpu_pkg;

    localparam int unsigned CPU_DATA_WIDTH   = 32;
    localparam int unsigned CPU_OFFSET_WIDTH = 19;
    localparam int unsigned CPU_RESET_PC     = 0;

    // IR field positions: C2 condition select and the branch constant
    localparam int unsigned IR_C2_MSB    = 20;
    localparam int unsigned IR_C2_LSB    = 19;
    localparam int unsigned IR_CONST_MSB = 18;
    localparam int unsigned IR_CONST_LSB = 0;

    typedef enum logic [1:0] {
        BR_IDLE   = 2'b00,
        BR_SAMPLE = 2'b01,
        BR_UPDATE = 2'b10
    } br_state_e;

endpackage

// File: rtl/pc_adder.sv
// Modulo-2^WIDTH adder shared by the fetch increment and the branch update.
//   a_i   : current PC
//   b_i   : addend (1 for IncPC, sign-extended offset for a taken branch)
//   sum_o : a_i + b_i, wrapping
module pc_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter plus branch-resolution sequencer (IDLE -> SAMPLE -> UPDATE).
//   clock, clear : system clock, asynchronous active-high reset
//   PCin         : load PC from BusMuxOut (highest priority, aborts a branch)
//   IncPC        : PC + 1 in IDLE, ignored while a branch is in flight
//   BranchEval   : starts branch resolution, offset taken from IRout
//   ConFFOut     : condition flag, sampled one cycle after BranchEval
//   IRout        : instruction register, low bits hold the branch constant
//   BusMuxOut    : load value for PCin
//   PCout_q      : current PC
//   BranchTaken  : result of the last completed branch
//   BranchBusy   : branch resolution in progress
module pc_branch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = CPU_DATA_WIDTH,
    parameter int unsigned OFFSET_WIDTH = CPU_OFFSET_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(CPU_RESET_PC)
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  PCin,
    input  logic                  IncPC,
    input  logic                  BranchEval,
    input  logic                  ConFFOut,
    input  logic [DATA_WIDTH-1:0] IRout,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    output logic [DATA_WIDTH-1:0] PCout_q,
    output logic                  BranchTaken,
    output logic                  BranchBusy
);

    br_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] off_q, off_d;
    logic                  take_q, take_d;
    logic                  taken_q, taken_d;

    logic [DATA_WIDTH-1:0] off_sext;
    logic [DATA_WIDTH-1:0] add_b;
    logic [DATA_WIDTH-1:0] add_sum;
    logic                  upd_taken;

    // Only the branch constant field is consumed here
    logic unused_ir_bits;
    assign unused_ir_bits = ^{IRout[DATA_WIDTH-1:OFFSET_WIDTH], IRout[IR_C2_MSB:IR_C2_LSB],
                              IRout[IR_CONST_MSB:IR_CONST_LSB]};

    assign off_sext  = {{(DATA_WIDTH-OFFSET_WIDTH){IRout[OFFSET_WIDTH-1]}},
                        IRout[OFFSET_WIDTH-1:0]};
    assign upd_taken = (state_q == BR_UPDATE) && take_q;

    // One adder serves both the increment and the branch target
    assign add_b = upd_taken ? off_q : DATA_WIDTH'(1);

    pc_adder #(
        .WIDTH (DATA_WIDTH)
    ) u_pc_adder (
        .a_i   (pc_q),
        .b_i   (add_b),
        .sum_o (add_sum)
    );

    // Next-state and next-PC selection
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        off_d   = off_q;
        take_d  = take_q;
        taken_d = taken_q;

        // PC priority: PCin > taken-branch update > IncPC (IDLE only)
        if (PCin) begin
            pc_d = BusMuxOut;
        end else if (upd_taken) begin
            pc_d = add_sum;
        end else if (IncPC && (state_q == BR_IDLE)) begin
            pc_d = add_sum;
        end

        unique case (state_q)
            BR_IDLE: begin
                if (BranchEval) begin
                    off_d   = off_sext;
                    state_d = BR_SAMPLE;
                end
            end
            BR_SAMPLE: begin
                take_d  = ConFFOut;
                state_d = PCin ? BR_IDLE : BR_UPDATE;
            end
            BR_UPDATE: begin
                // A PCin abort leaves the previous result visible
                if (!PCin) begin
                    taken_d = take_q;
                end
                state_d = BR_IDLE;
            end
            default: state_d = BR_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= BR_IDLE;
            pc_q    <= RESET_PC;
            off_q   <= '0;
            take_q  <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            off_q   <= off_d;
            take_q  <= take_d;
            taken_q <= taken_d;
        end
    end

    assign PCout_q     = pc_q;
    assign BranchTaken = taken_q;
    assign BranchBusy  = (state_q != BR_IDLE);

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: fetch, taken/not-taken/backward branches,
// abort and collision cases, and asynchronous clear.
module tb_pc_branch_unit;

    logic        clock;
    logic        clear;
    logic        PCin;
    logic        IncPC;
    logic        BranchEval;
    logic        ConFFOut;
    logic [31:0] IRout;
    logic [31:0] BusMuxOut;
    logic [31:0] PCout_q;
    logic        BranchTaken;
    logic        BranchBusy;

    int checks_cnt;
    int fail_cnt;

    pc_branch_unit dut (
        .clock       (clock),
        .clear       (clear),
        .PCin        (PCin),
        .IncPC       (IncPC),
        .BranchEval  (BranchEval),
        .ConFFOut    (ConFFOut),
        .IRout       (IRout),
        .BusMuxOut   (BusMuxOut),
        .PCout_q     (PCout_q),
        .BranchTaken (BranchTaken),
        .BranchBusy  (BranchBusy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_pc(input logic [31:0] v);
        PCin      = 1'b1;
        BusMuxOut = v;
        tick();
        PCin      = 1'b0;
    endtask

    // Issue a BranchEval pulse and run through SAMPLE and UPDATE
    task automatic run_branch(input logic [31:0] ir, input logic con);
        IRout      = ir;
        ConFFOut   = con;
        BranchEval = 1'b1;
        tick();
        BranchEval = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        clear      = 1'b1;
        PCin       = 1'b0;
        IncPC      = 1'b0;
        BranchEval = 1'b0;
        ConFFOut   = 1'b0;
        IRout      = '0;
        BusMuxOut  = '0;
        #12;
        chk("reset_pc", PCout_q, 32'h0);
        chk("reset_taken", 32'(BranchTaken), 32'h0);
        chk("reset_busy", 32'(BranchBusy), 32'h0);
        clear = 1'b0;
        tick();

        // Fetch increment, then IncPC+PCin together
        load_pc(32'h10);
        IncPC = 1'b1;
        tick();
        IncPC = 1'b0;
        chk("incpc", PCout_q, 32'h11);
        IncPC     = 1'b1;
        PCin      = 1'b1;
        BusMuxOut = 32'h200;
        tick();
        IncPC = 1'b0;
        PCin  = 1'b0;
        chk("pcin_over_inc", PCout_q, 32'h200);

        // Taken forward branch, bit 19 set to confirm it is not the sign bit
        load_pc(32'h20);
        IRout      = 32'hFFF8_0005;
        ConFFOut   = 1'b1;
        BranchEval = 1'b1;
        tick();
        BranchEval = 1'b0;
        chk("taken_busy1", 32'(BranchBusy), 32'h1);
        chk("taken_pc_hold1", PCout_q, 32'h20);
        tick();
        chk("taken_busy2", 32'(BranchBusy), 32'h1);
        chk("taken_pc_hold2", PCout_q, 32'h20);
        tick();
        chk("taken_pc", PCout_q, 32'h25);
        chk("taken_flag", 32'(BranchTaken), 32'h1);
        chk("taken_idle", 32'(BranchBusy), 32'h0);

        // Not taken
        load_pc(32'h20);
        run_branch(32'h0000_0005, 1'b0);
        chk("nt_pc", PCout_q, 32'h20);
        chk("nt_flag", 32'(BranchTaken), 32'h0);

        // Taken backward branch wrapping below zero
        load_pc(32'h3);
        run_branch(32'hABC7_FFFC, 1'b1);
        chk("back_pc", PCout_q, 32'hFFFF_FFFF);
        chk("back_flag", 32'(BranchTaken), 32'h1);

        // Forward wrap above max
        load_pc(32'hFFFF_FFFE);
        run_branch(32'h0000_0003, 1'b1);
        chk("wrap_pc", PCout_q, 32'h1);

        // Abort via PCin during SAMPLE; BranchTaken keeps its previous 1
        load_pc(32'h40);
        IRout      = 32'h0000_0007;
        ConFFOut   = 1'b1;
        BranchEval = 1'b1;
        tick();
        BranchEval = 1'b0;
        PCin       = 1'b1;
        BusMuxOut  = 32'h80;
        tick();
        PCin = 1'b0;
        chk("abort_pc", PCout_q, 32'h80);
        chk("abort_idle", 32'(BranchBusy), 32'h0);
        chk("abort_flag", 32'(BranchTaken), 32'h1);
        tick();
        tick();
        chk("abort_no_late_update", PCout_q, 32'h80);

        // BranchEval and IncPC while busy are ignored
        load_pc(32'h50);
        IRout      = 32'h0000_0010;
        ConFFOut   = 1'b1;
        BranchEval = 1'b1;
        tick();
        IRout = 32'h0000_0100;
        IncPC = 1'b1;
        tick();
        chk("busy_inc_ignored", PCout_q, 32'h50);
        chk("busy_still", 32'(BranchBusy), 32'h1);
        tick();
        BranchEval = 1'b0;
        IncPC      = 1'b0;
        chk("busy_off_kept", PCout_q, 32'h60);
        chk("busy_done", 32'(BranchBusy), 32'h0);

        // Asynchronous clear while in UPDATE with a taken condition
        load_pc(32'h30);
        IRout      = 32'h0000_0005;
        ConFFOut   = 1'b1;
        BranchEval = 1'b1;
        tick();
        BranchEval = 1'b0;
        tick();
        chk("pre_clear_busy", 32'(BranchBusy), 32'h1);
        #1 clear = 1'b1;
        #1;
        chk("clear_pc", PCout_q, 32'h0);
        chk("clear_busy", 32'(BranchBusy), 32'h0);
        chk("clear_taken", 32'(BranchTaken), 32'h0);
        tick();
        clear = 1'b0;
        tick();
        tick();
        chk("post_clear_pc", PCout_q, 32'h0);
        chk("post_clear_taken", 32'(BranchTaken), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
